// File: rtl/alu_mc_pkg.sv
// Shared funct encodings, FSM state constants and the result flag bundle for alu_mc.
// Latency and back-pressure are properties of alu_mc itself; this package only defines types.
package alu_mc_pkg;

  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  typedef struct packed {
    logic zero;
    logic overflow;
    logic illegal;
  } flags_t;

endpackage

// File: rtl/alu_mc_if.sv
// Issue/result bundle between decode and writeback: valid/ready on both sides.
// The ALU side uses the slave modport, the decode/writeback side the master modport.
interface alu_mc_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic [5:0]       Signal;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] dataOut;
  logic             zero;
  logic             overflow;
  logic             illegal;

  modport master (
    output in_valid, dataA, dataB, Signal, out_ready,
    input  in_ready, out_valid, dataOut, zero, overflow, illegal
  );

  modport slave (
    input  in_valid, dataA, dataB, Signal, out_ready,
    output in_ready, out_valid, dataOut, zero, overflow, illegal
  );
endinterface

// File: rtl/alu_mc_mul_seq.sv
// Shift-add unsigned multiplier: first step on the start cycle, WIDTH steps total, done with product on the last.
// No back-pressure: the caller only starts it when it can take the product.
module alu_mc_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, step_in;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;

  // acc holds {partial high, remaining multiplier bits}; each step adds and shifts right by one
  always_comb begin
    step_in = start ? {{WIDTH{1'b0}}, b} : acc_q;
    addend  = step_in[0] ? (start ? a : mcand_q) : {WIDTH{1'b0}};
    sum     = {1'b0, step_in[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    acc_d   = {sum, step_in[WIDTH-1:1]};
    mcand_d = start ? a : mcand_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = CW'(WIDTH - 1);
    end else if (busy_q) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done   = 1'b1;
      end
    end else begin
      acc_d = acc_q;
    end
    product = acc_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end
endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with registered result: latency 1 for single-cycle ops, WIDTH for MULTU into HI/LO.
// Output holds while out_valid && !out_ready; in_ready drops during MUL and while the result slot is blocked.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit ENABLE_MUL = 1'b1
) (
  input logic    clk,
  input logic    reset,
  alu_mc_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  logic [0:0]         state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   data_q, data_d;
  flags_t             flags_q, flags_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic [WIDTH-1:0]   a, b, sum, diff, res;
  logic [SHW-1:0]     shamt;
  logic               ovf_add, ovf_sub, lt, ovf, op_ill, is_mul_op;
  logic               accept, mul_start, mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  flags_t             res_flags;

  assign a       = bus.dataA;
  assign b       = bus.dataB;
  assign sum     = a + b;
  assign diff    = a - b;
  assign ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
  // the raw sign of a-b lies exactly when the subtraction overflowed
  assign lt      = diff[WIDTH-1] ^ ovf_sub;
  assign shamt   = b[SHW-1:0];

  assign bus.in_ready = !reset && (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    res       = '0;
    ovf       = 1'b0;
    op_ill    = 1'b0;
    is_mul_op = 1'b0;
    case (bus.Signal)
      F_AND:   res = a & b;
      F_OR:    res = a | b;
      F_ADD:   begin res = sum;  ovf = ovf_add; end
      F_SUB:   begin res = diff; ovf = ovf_sub; end
      F_SLT:   res = {{(WIDTH-1){1'b0}}, lt};
      F_SLL:   res = a << shamt;
      F_SRL:   res = a >> shamt;
      F_MULTU: if (ENABLE_MUL) is_mul_op = 1'b1; else op_ill = 1'b1;
      F_MFHI:  if (ENABLE_MUL) res = hi_q;      else op_ill = 1'b1;
      F_MFLO:  if (ENABLE_MUL) res = lo_q;      else op_ill = 1'b1;
      default: op_ill = 1'b1;
    endcase
    res_flags.zero     = (res == '0);
    res_flags.overflow = ovf;
    res_flags.illegal  = op_ill;
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    data_d      = data_q;
    flags_d     = flags_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    mul_start   = 1'b0;
    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
    if (accept) begin
      if (is_mul_op) begin
        state_d   = S_MUL;
        mul_start = 1'b1;
      end else begin
        out_valid_d = 1'b1;
        data_d      = res;
        flags_d     = res_flags;
      end
    end
    if ((state_q == S_MUL) && mul_done) begin
      {hi_d, lo_d}     = mul_prod;
      data_d           = mul_prod[WIDTH-1:0];
      flags_d          = '0;
      flags_d.zero     = (mul_prod[WIDTH-1:0] == '0);
      out_valid_d      = 1'b1;
      state_d          = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      flags_q     <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      flags_q     <= flags_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  generate
    if (ENABLE_MUL) begin : g_mul
      alu_mc_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_prod)
      );
    end else begin : g_nomul
      assign mul_done = 1'b0;
      assign mul_prod = '0;
    end
  endgenerate

  assign bus.out_valid = out_valid_q;
  assign bus.dataOut   = data_q;
  assign bus.zero      = flags_q.zero;
  assign bus.overflow  = flags_q.overflow;
  assign bus.illegal   = flags_q.illegal;
endmodule
